// File: rtl/z80_io_portbank.sv
// z80_io_portbank: NPORTS consecutive Z80 I/O ports with latched output registers,
// per-port read source, programmable WAIT insertion and one-cycle access strobes.
module z80_io_portbank #(
  parameter int          NPORTS      = 4,
  parameter logic [7:0]  BASE        = 8'hEC,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [7:0]  RESET_VAL   = 8'h00,
  parameter logic [7:0]  RD_MODE     = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iorq,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  m1,
  input  logic [7:0]            A,
  input  logic [7:0]            D_in,
  output logic [7:0]            D_out,
  output logic                  D_oe,
  input  logic                  jump,
  input  logic [NPORTS*8-1:0]   ext_din,
  output logic [NPORTS*8-1:0]   port_q,
  output logic [NPORTS-1:0]     wr_stb,
  output logic [NPORTS-1:0]     rd_stb,
  output logic                  sel,
  output logic                  wait_n
);

  typedef enum logic [1:0] {S_HOLD, S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   wr_done_q, rd_done_q, wait_n_q;
  logic [NPORTS-1:0][7:0] lane_q;

  logic [7:0] a_off;
  logic [2:0] idx;
  logic       in_rng, hit, active, wr_fire, rd_fire;

  // A >= BASE guarantees a_off did not wrap, so the offset compare bounds the range.
  assign a_off  = A - BASE;
  assign idx    = a_off[2:0];
  assign in_rng = (A >= BASE) && (a_off < 8'(NPORTS));
  assign hit    = jump & ~iorq & m1 & in_rng;
  assign sel    = hit;
  assign D_oe   = hit & ~rd & wr;
  assign active = (state_q != S_HOLD);
  assign wr_fire = active & hit & ~wr & ~wr_done_q;
  assign rd_fire = active & hit & ~rd & wr & ~rd_done_q;
  assign wait_n  = wait_n_q;
  assign port_q  = lane_q;

  always_comb begin
    D_out = '0;
    for (int i = 0; i < NPORTS; i++)
      if (idx == 3'(i)) D_out = RD_MODE[i] ? ext_din[8*i +: 8] : lane_q[i];
  end

  // Access sequencer: HOLD is the only way back to IDLE, so one I/O cycle is one access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      cnt_q     <= 4'd0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      wait_n_q  <= 1'b1;
    end else begin
      if (wr_fire) wr_done_q <= 1'b1;
      if (rd_fire) rd_done_q <= 1'b1;
      case (state_q)
        S_HOLD: begin
          wr_done_q <= 1'b0;
          rd_done_q <= 1'b0;
          if (iorq) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (hit) begin
            if (WAIT_CYCLES > 0) begin
              state_q  <= S_WAIT;
              cnt_q    <= CNT_LOAD;
              wait_n_q <= 1'b0;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0 || !jump) begin
            state_q  <= S_HOLD;
            cnt_q    <= 4'd0;
            wait_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= S_HOLD;
      endcase
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    z80_io_port_lane #(.RESET_VAL(RESET_VAL)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr_en_i  (wr_fire & (idx == 3'(i))),
      .rd_en_i  (rd_fire & (idx == 3'(i))),
      .din_i    (D_in),
      .q_o      (lane_q[i]),
      .wr_stb_o (wr_stb[i]),
      .rd_stb_o (rd_stb[i])
    );
  end

endmodule

// One port: latched output register plus registered access strobes.
module z80_io_port_lane #(
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_i,
  input  logic       rd_en_i,
  input  logic [7:0] din_i,
  output logic [7:0] q_o,
  output logic       wr_stb_o,
  output logic       rd_stb_o
);

  logic [7:0] q_q;
  logic       wr_stb_q, rd_stb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= RESET_VAL;
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
    end else begin
      if (wr_en_i) q_q <= din_i;
      wr_stb_q <= wr_en_i;
      rd_stb_q <= rd_en_i;
    end
  end

  assign q_o      = q_q;
  assign wr_stb_o = wr_stb_q;
  assign rd_stb_o = rd_stb_q;

endmodule
